// File: rtl/keydev_pkg.sv
// Shared constants for the KEY device: bus addresses, KCTRL bit layout, key count.
package keydev_pkg;

   localparam int          KEY_N         = 4;
   localparam logic [31:0] ADDR_KDATA_DEF = 32'hFFFF_F080;
   localparam logic [31:0] ADDR_KCTRL_DEF = 32'hFFFF_F084;

   localparam int KCTRL_READY   = 0;
   localparam int KCTRL_OVERRUN = 2;
   localparam int KCTRL_IE      = 8;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer for the (already inverted) key inputs, followed by an
// optional debounce counter. Emits the accepted key state and a combinational
// `changed` flag that is high in the cycle before key_state takes a new value.
// Build option: KEY_IO_RESPONDER_DEBOUNCE_EN enables the debounce counter.
module key_debounce
   import keydev_pkg::*;
#(
   parameter int N               = KEY_N,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] key_raw,
   output logic [N-1:0] key_state,
   output logic         changed
);

   logic [N-1:0] s1_q, s1_d;
   logic [N-1:0] s2_q, s2_d;
   logic [N-1:0] state_q, state_d;

   // Synchronizer stages simply shift the raw inputs through.
   always_comb begin
      s1_d = key_raw;
      s2_d = s1_q;
   end

`ifdef KEY_IO_RESPONDER_DEBOUNCE_EN
   localparam int            CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Accept s2 once it has differed from key_state for DEBOUNCE_CYCLES cycles;
   // acceptance takes priority over the restart caused by s2 changing again.
   always_comb begin
      cnt_d   = cnt_q;
      state_d = state_q;
      if (s2_q == state_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX - 1'b1) begin
         state_d = s2_q;
         cnt_d   = '0;
      end else if (s1_q != s2_q) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Debounce counter register.
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`else
   logic [31:0] unused_debounce_cycles;
   assign unused_debounce_cycles = DEBOUNCE_CYCLES;

   // Without debounce the synchronized value is taken every cycle.
   always_comb begin
      state_d = s2_q;
   end
`endif

   // Synchronizer and accepted-state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q    <= '0;
         s2_q    <= '0;
         state_q <= '0;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         state_q <= state_d;
      end
   end

   assign key_state = state_q;
   assign changed   = (state_d != state_q);

endmodule

// File: rtl/key_io_responder.sv
// KEY device bus responder: KDATA (read-only key state) and KCTRL
// (ready / overrun / interrupt-enable). Reads are combinational, side effects
// occur at the closing clock edge. irq = ie & ready.
// Build option: KEY_IO_RESPONDER_DEBOUNCE_EN enables key debouncing.
module key_io_responder
   import keydev_pkg::*;
#(
   parameter int                DBITS           = 32,
   parameter logic [DBITS-1:0]  ADDR_KDATA      = DBITS'(ADDR_KDATA_DEF),
   parameter logic [DBITS-1:0]  ADDR_KCTRL      = DBITS'(ADDR_KCTRL_DEF),
   parameter int                DEBOUNCE_CYCLES = 500000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DBITS-1:0] addr,
   input  logic             rd_en,
   input  logic             wr_en,
   input  logic [DBITS-1:0] wdata,
   input  logic [3:0]       key_n,
   output logic [DBITS-1:0] rdata,
   output logic             hit,
   output logic             irq
);

   logic [KEY_N-1:0] key_state;
   logic             changed;

   logic ready_q, ready_d;
   logic overrun_q, overrun_d;
   logic ie_q, ie_d;

   logic sel_kdata, sel_kctrl;
   logic kdata_rd, kctrl_wr;

   logic [DBITS-1:0] unused_wdata;
   assign unused_wdata = wdata;

   key_debounce #(
      .N               (KEY_N),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk       (clk),
      .reset     (reset),
      .key_raw   (~key_n),
      .key_state (key_state),
      .changed   (changed)
   );

   assign sel_kdata = (addr == ADDR_KDATA);
   assign sel_kctrl = (addr == ADDR_KCTRL);
   assign hit       = sel_kdata | sel_kctrl;
   // A simultaneous write suppresses the read side effect.
   assign kdata_rd  = rd_en & ~wr_en & sel_kdata;
   assign kctrl_wr  = wr_en & sel_kctrl;

   // Flag updates; key-change events are applied last so they win over clears.
   always_comb begin
      ready_d   = ready_q;
      overrun_d = overrun_q;
      ie_d      = ie_q;
      if (kdata_rd) ready_d = 1'b0;
      if (kctrl_wr) begin
         ie_d = wdata[KCTRL_IE];
         if (!wdata[KCTRL_READY])   ready_d   = 1'b0;
         if (!wdata[KCTRL_OVERRUN]) overrun_d = 1'b0;
      end
      if (changed) begin
         if (ready_q && !kdata_rd) overrun_d = 1'b1;
         ready_d = 1'b1;
      end
   end

   // Status/control registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         ready_q   <= 1'b0;
         overrun_q <= 1'b0;
         ie_q      <= 1'b0;
      end else begin
         ready_q   <= ready_d;
         overrun_q <= overrun_d;
         ie_q      <= ie_d;
      end
   end

   // Combinational read mux; zero for addresses outside the device.
   always_comb begin
      rdata = '0;
      if (sel_kdata) begin
         rdata[KEY_N-1:0] = key_state;
      end else if (sel_kctrl) begin
         rdata[KCTRL_READY]   = ready_q;
         rdata[KCTRL_OVERRUN] = overrun_q;
         rdata[KCTRL_IE]      = ie_q;
      end
   end

   assign irq = ie_q & ready_q;

endmodule
